adc_serial_responder: RTL and testbench

//  Synthesizable model of the ADC side of the ADC serial link (SCLK/CS_n/DIN/DOUT).

---
 rtl/adc_serial_responder.sv | 194 +++++++++++++++++++
 tb/tb_adc_serial_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_responder.sv
// ADC-side responder for the SCLK/CS_n/DIN/DOUT link: captures the controller's
// command word and returns either a host-loaded word or an internal ramp.
module adc_serial_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RAMP_STEP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  sdi,
  output logic                  sdo,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load,
  input  logic                  ramp_mode,
  output logic [FRAME_BITS-1:0] cmd_word,
  output logic                  cmd_valid,
  output logic                  frame_err,
  output logic [15:0]           frame_count
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FRAME_BITS);
  localparam logic [FRAME_BITS-1:0] STEP     = FRAME_BITS'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   cs_dly_q, cs_dly_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  rx_sr_q, rx_sr_d;
  logic [FRAME_BITS-1:0]  tx_sr_q, tx_sr_d;
  logic [FRAME_BITS-1:0]  tx_hold_q, tx_hold_d;
  logic [FRAME_BITS-1:0]  ramp_q, ramp_d;
  logic [FRAME_BITS-1:0]  cmd_word_q, cmd_word_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   sdo_q, sdo_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sclk_s, cs_s, sdi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [FRAME_BITS-1:0]  load_word;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
    cs_dly_d    = cs_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
    end
  end

  // sdi is taken from the same stage as sclk so the data bit lines up with its edge
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // A tx_load coinciding with the cs_n fall is forwarded into the frame being started
  always_comb begin
    tx_hold_d = tx_load ? tx_data : tx_hold_q;
    load_word = ramp_mode ? ramp_q : tx_hold_d;
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    sdo_d         = sdo_q;
    cmd_word_d    = cmd_word_q;
    cmd_valid_d   = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    ramp_d        = ramp_q;

    case (state_q)
      IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall) begin
          tx_sr_d   = load_word;
          sdo_d     = load_word[FRAME_BITS-1];
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          state_d   = SHIFT;
        end
      end

      // cs_n edges take priority; an sclk edge in the same cycle is dropped
      SHIFT: begin
        if (cs_rise) begin
          sdo_d = 1'b0;
          if (bit_cnt_q == FULL_CNT) begin
            // Results are registered on entry to DONE so cmd_word is valid with cmd_valid
            state_d       = DONE;
            cmd_word_d    = rx_sr_q;
            cmd_valid_d   = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            ramp_d        = ramp_q + STEP;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (sclk_rise) begin
          if (bit_cnt_q < FULL_CNT) begin
            rx_sr_d   = {rx_sr_q[FRAME_BITS-2:0], sdi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q < FULL_CNT) begin
            tx_sr_d = tx_sr_q << 1;
            sdo_d   = tx_sr_q[FRAME_BITS-2];
          end else begin
            sdo_d = 1'b0;
          end
        end
      end

      DONE: begin
        sdo_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        sdo_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      tx_hold_q     <= '0;
      ramp_q        <= '0;
      sdo_q         <= 1'b0;
      cmd_word_q    <= '0;
      cmd_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      tx_hold_q     <= tx_hold_d;
      ramp_q        <= ramp_d;
      sdo_q         <= sdo_d;
      cmd_word_q    <= cmd_word_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sdo         = sdo_q;
  assign cmd_word    = cmd_word_q;
  assign cmd_valid   = cmd_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: acts as the ADC controller, shifting
// command words in and collecting returned words, with hand-computed expectations.
module tb_adc_serial_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs_n;
  logic        sdi;
  logic        sdo;
  logic [15:0] tx_data;
  logic        tx_load;
  logic        ramp_mode;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic        frame_err;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int validCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  adc_serial_responder #(
    .FRAME_BITS(16),
    .SYNC_STAGES(2),
    .RAMP_STEP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .cs_n(cs_n),
    .sdi(sdi),
    .sdo(sdo),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .ramp_mode(ramp_mode),
    .cmd_word(cmd_word),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .frame_count(frame_count)
  );

  // Pulse counters; tests compare deltas taken around each frame
  always @(negedge clk) begin
    if (cmd_valid) validCount++;
    if (frame_err) errCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One controller bit: drive sdi, sample sdo just before the rising edge
  task automatic shiftBit(input logic din, output logic dout);
    sdi = din;
    repeat (4) @(negedge clk);
    dout = sdo;
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // loadAt: <0 none, 0 = tx_load in the cycle the cs_n fall is processed, k>0 = before bit k
  task automatic applyStimulus(input logic [15:0] cmd, input int nBits, input int loadAt,
                               input logic [15:0] loadWord, output logic [15:0] rxWord,
                               output logic tailSdo);
    logic d;
    rxWord  = '0;
    tailSdo = 1'b0;
    cs_n    = 1'b0;
    if (loadAt == 0) begin
      repeat (2) @(negedge clk);
      tx_data = loadWord;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    for (int i = 0; i < nBits; i++) begin
      if (loadAt > 0 && i == loadAt) begin
        tx_data = loadWord;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
      end
      shiftBit((i < 16) ? cmd[15-i] : 1'b1, d);
      if (i < 16) rxWord = {rxWord[14:0], d};
      else tailSdo = tailSdo | d;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rx;
    logic        tail;
    logic        d;
    int          v0, e0;

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    tx_data = '0; tx_load = 1'b0; ramp_mode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sdo", {31'b0, sdo}, 32'h0);
    checkOutput("rst_cmd_word", {16'b0, cmd_word}, 32'h0);
    checkOutput("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    checkOutput("rst_frame_err", {31'b0, frame_err}, 32'h0);
    checkOutput("rst_frame_count", {16'b0, frame_count}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] host word frame");
    tx_data = 16'hA5C3; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    v0 = validCount; e0 = errCount;
    applyStimulus(16'h1234, 16, -1, 16'h0, rx, tail);
    checkOutput("t1_sdo_word", {16'b0, rx}, 32'hA5C3);
    checkOutput("t1_cmd_word", {16'b0, cmd_word}, 32'h1234);
    checkOutput("t1_valid_pulses", validCount - v0, 1);
    checkOutput("t1_err_pulses", errCount - e0, 0);
    checkOutput("t1_frame_count", {16'b0, frame_count}, 32'h1);

    $display("[TB] ramp frames");
    doReset();
    ramp_mode = 1'b1;
    v0 = validCount;
    applyStimulus(16'h0F0F, 16, -1, 16'h0, rx, tail);
    checkOutput("t2_ramp0", {16'b0, rx}, 32'h0000);
    applyStimulus(16'hF0F0, 16, -1, 16'h0, rx, tail);
    checkOutput("t2_ramp1", {16'b0, rx}, 32'h0001);
    applyStimulus(16'h8001, 16, -1, 16'h0, rx, tail);
    checkOutput("t2_ramp2", {16'b0, rx}, 32'h0002);
    checkOutput("t2_frame_count", {16'b0, frame_count}, 32'h3);
    checkOutput("t2_valid_pulses", validCount - v0, 3);
    checkOutput("t2_cmd_word", {16'b0, cmd_word}, 32'h8001);

    $display("[TB] short frame");
    v0 = validCount; e0 = errCount;
    applyStimulus(16'h7777, 9, -1, 16'h0, rx, tail);
    checkOutput("t3_err_pulses", errCount - e0, 1);
    checkOutput("t3_valid_pulses", validCount - v0, 0);
    checkOutput("t3_cmd_word", {16'b0, cmd_word}, 32'h8001);
    checkOutput("t3_frame_count", {16'b0, frame_count}, 32'h3);
    applyStimulus(16'h4242, 16, -1, 16'h0, rx, tail);
    checkOutput("t3_next_ramp", {16'b0, rx}, 32'h0003);
    checkOutput("t3_next_cmd", {16'b0, cmd_word}, 32'h4242);
    checkOutput("t3_next_count", {16'b0, frame_count}, 32'h4);

    $display("[TB] overlong frame");
    v0 = validCount;
    applyStimulus(16'hC3A5, 20, -1, 16'h0, rx, tail);
    checkOutput("t4_ramp", {16'b0, rx}, 32'h0004);
    checkOutput("t4_tail_sdo", {31'b0, tail}, 32'h0);
    checkOutput("t4_cmd_word", {16'b0, cmd_word}, 32'hC3A5);
    checkOutput("t4_valid_pulses", validCount - v0, 1);
    checkOutput("t4_frame_count", {16'b0, frame_count}, 32'h5);

    $display("[TB] reset mid-frame");
    v0 = validCount; e0 = errCount;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) shiftBit(i[0], d);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t5_rst_sdo", {31'b0, sdo}, 32'h0);
    checkOutput("t5_rst_cmd_word", {16'b0, cmd_word}, 32'h0);
    checkOutput("t5_rst_count", {16'b0, frame_count}, 32'h0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("t5_no_valid", validCount - v0, 0);
    checkOutput("t5_no_err", errCount - e0, 0);
    ramp_mode = 1'b0;
    applyStimulus(16'h5A3C, 16, -1, 16'h0, rx, tail);
    checkOutput("t5_clean_sdo", {16'b0, rx}, 32'h0000);
    checkOutput("t5_clean_cmd", {16'b0, cmd_word}, 32'h5A3C);
    checkOutput("t5_clean_valid", validCount - v0, 1);
    checkOutput("t5_clean_count", {16'b0, frame_count}, 32'h1);

    $display("[TB] load during frame");
    tx_data = 16'h1111; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    applyStimulus(16'h0001, 16, 6, 16'hBEEF, rx, tail);
    checkOutput("t6_current", {16'b0, rx}, 32'h1111);
    applyStimulus(16'h0002, 16, -1, 16'h0, rx, tail);
    checkOutput("t6_next", {16'b0, rx}, 32'hBEEF);

    $display("[TB] load at frame start");
    applyStimulus(16'h0003, 16, 0, 16'h5A5A, rx, tail);
    checkOutput("t7_forward", {16'b0, rx}, 32'h5A5A);
    checkOutput("t7_frame_count", {16'b0, frame_count}, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
